// File: rtl/decode_stage_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | decode_stage_if : fetch, register-file and execute signals of decode |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface decode_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [4:0]  rf_a1;
  logic [4:0]  rf_a2;
  logic [31:0] rf_rd1;
  logic [31:0] rf_rd2;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_rs1_val;
  logic [31:0] out_rs2_val;
  logic [31:0] out_imm;
  logic [4:0]  out_rd;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic        out_funct7b5;
  logic        out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, rf_rd1, rf_rd2,
    input  wb_we, wb_addr, wb_data, out_ready,
    output in_ready, rf_a1, rf_a2, out_valid, out_pc,
    output out_rs1_val, out_rs2_val, out_imm, out_rd,
    output out_opcode, out_funct3, out_funct7b5, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, rf_rd1, rf_rd2,
    output wb_we, wb_addr, wb_data, out_ready,
    input  in_ready, rf_a1, rf_a2, out_valid, out_pc,
    input  out_rs1_val, out_rs2_val, out_imm, out_rd,
    input  out_opcode, out_funct3, out_funct7b5, out_illegal
  );
endinterface
`default_nettype wire

// File: rtl/decode_stage.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | decode_stage : RV32 decode / register read with writeback forwarding |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module decode_stage (
  input  logic           clk,
  input  logic           rst,
  decode_stage_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_CAPT  = 2'd2;
  localparam logic [1:0] S_VALID = 2'd3;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  logic [1:0]  r_state;
  logic [1:0]  w_next;
  logic        w_in_ready;
  logic        w_out_valid;
  logic        w_accept;

  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic        r_pend1;
  logic        r_pend2;
  logic [31:0] r_pend1_val;
  logic [31:0] r_pend2_val;

  logic [31:0] r_out_pc;
  logic [31:0] r_out_rs1_val;
  logic [31:0] r_out_rs2_val;
  logic [31:0] r_out_imm;
  logic [4:0]  r_out_rd;
  logic [6:0]  r_out_opcode;
  logic [2:0]  r_out_funct3;
  logic        r_out_funct7b5;
  logic        r_out_illegal;

  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic        w_wb1;
  logic        w_wb2;
  logic [31:0] w_op1;
  logic [31:0] w_op2;
  logic [31:0] w_imm;
  logic        w_illegal;

  assign w_rs1 = r_instr[19:15];
  assign w_rs2 = r_instr[24:20];
  assign w_wb1 = bus.wb_we && (bus.wb_addr == w_rs1) && (w_rs1 != 5'd0);
  assign w_wb2 = bus.wb_we && (bus.wb_addr == w_rs2) && (w_rs2 != 5'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid) w_next = S_READ;
      S_READ:  w_next = S_CAPT;
      S_CAPT:  w_next = S_VALID;
      S_VALID: if (bus.out_ready) w_next = bus.in_valid ? S_READ : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_IDLE:  w_in_ready = 1'b1;
      S_VALID: begin
        w_out_valid = 1'b1;
        w_in_ready  = bus.out_ready;
      end
      default: ;
    endcase
  end

  assign w_accept = bus.in_valid && w_in_ready;

  // Every supported opcode ends in 2'b11, so the low-bit check folds into the default arm.
  always_comb begin
    w_imm     = 32'd0;
    w_illegal = 1'b0;
    case (r_instr[6:0])
      OP_IMM, OP_LOAD, OP_JALR:
        w_imm = {{20{r_instr[31]}}, r_instr[31:20]};
      OP_STORE:
        w_imm = {{20{r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
      OP_BRANCH:
        w_imm = {{19{r_instr[31]}}, r_instr[31], r_instr[7], r_instr[30:25], r_instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        w_imm = {r_instr[31:12], 12'd0};
      OP_JAL:
        w_imm = {{11{r_instr[31]}}, r_instr[31], r_instr[19:12], r_instr[20], r_instr[30:21], 1'b0};
      OP_OP:
        w_imm = 32'd0;
      default:
        w_illegal = 1'b1;
    endcase
  end

  // Register file returns pre-write data, so a live write beats the slot captured at READ exit.
  assign w_op1 = (w_rs1 == 5'd0) ? 32'd0 : w_wb1 ? bus.wb_data : r_pend1 ? r_pend1_val : bus.rf_rd1;
  assign w_op2 = (w_rs2 == 5'd0) ? 32'd0 : w_wb2 ? bus.wb_data : r_pend2 ? r_pend2_val : bus.rf_rd2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_instr        <= 32'd0;
      r_pc           <= 32'd0;
      r_pend1        <= 1'b0;
      r_pend2        <= 1'b0;
      r_pend1_val    <= 32'd0;
      r_pend2_val    <= 32'd0;
      r_out_pc       <= 32'd0;
      r_out_rs1_val  <= 32'd0;
      r_out_rs2_val  <= 32'd0;
      r_out_imm      <= 32'd0;
      r_out_rd       <= 5'd0;
      r_out_opcode   <= 7'd0;
      r_out_funct3   <= 3'd0;
      r_out_funct7b5 <= 1'b0;
      r_out_illegal  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_instr <= bus.in_instr;
        r_pc    <= bus.in_pc;
      end
      if (r_state == S_READ) begin
        r_pend1     <= w_wb1;
        r_pend2     <= w_wb2;
        r_pend1_val <= bus.wb_data;
        r_pend2_val <= bus.wb_data;
      end
      if (r_state == S_CAPT) begin
        r_out_pc       <= r_pc;
        r_out_rs1_val  <= w_op1;
        r_out_rs2_val  <= w_op2;
        r_out_imm      <= w_imm;
        r_out_rd       <= r_instr[11:7];
        r_out_opcode   <= r_instr[6:0];
        r_out_funct3   <= r_instr[14:12];
        r_out_funct7b5 <= r_instr[30];
        r_out_illegal  <= w_illegal;
      end else if (r_state == S_VALID) begin
        if (w_wb1) r_out_rs1_val <= bus.wb_data;
        if (w_wb2) r_out_rs2_val <= bus.wb_data;
      end
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = w_out_valid;
  assign bus.rf_a1        = w_rs1;
  assign bus.rf_a2        = w_rs2;
  assign bus.out_pc       = r_out_pc;
  assign bus.out_rs1_val  = r_out_rs1_val;
  assign bus.out_rs2_val  = r_out_rs2_val;
  assign bus.out_imm      = r_out_imm;
  assign bus.out_rd       = r_out_rd;
  assign bus.out_opcode   = r_out_opcode;
  assign bus.out_funct3   = r_out_funct3;
  assign bus.out_funct7b5 = r_out_funct7b5;
  assign bus.out_illegal  = r_out_illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_decode_stage : decode_stage with a behavioural register file      |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_decode_stage;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] cur_instr = 32'd0;
  logic [31:0] cur_pc    = 32'd0;
  logic [31:0] rf_mem [32];

  always #5 clk = ~clk;

  decode_stage_if dif ();
  decode_stage dut (.clk(clk), .rst(rst), .bus(dif));

  // Register file with a registered read that returns pre-write data; it also stores x0 writes.
  always @(posedge clk) begin
    dif.rf_rd1 <= rf_mem[dif.rf_a1];
    dif.rf_rd2 <= rf_mem[dif.rf_a2];
    if (dif.wb_we) rf_mem[dif.wb_addr] <= dif.wb_data;
  end

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ref_imm(input logic [31:0] i);
    int v;
    v = 0;
    case (i[6:0])
      7'h13, 7'h03, 7'h67: v = $signed(i[31:20]);
      7'h23:               v = $signed({i[31:25], i[11:7]});
      7'h63:               v = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
      7'h37, 7'h17:        v = {i[31:12], 12'h000};
      7'h6F:               v = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
      default:             v = 0;
    endcase
    return 32'(v);
  endfunction

  function automatic logic ref_illegal(input logic [31:0] i);
    return (i[1:0] != 2'b11) ||
           !(i[6:0] inside {7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33});
  endfunction

  function automatic logic [31:0] ref_op(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : rf_mem[a];
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [6:0]  ops [9] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = int'($urandom_range(0, 10));
    if (k < 9) return {r[31:7], ops[k]};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_wb();
    logic [31:0] r;
    r = $urandom;
    dif.wb_we   = r[0];
    dif.wb_addr = r[1] ? cur_instr[19:15] : (r[2] ? cur_instr[24:20] : r[7:3]);
    dif.wb_data = $urandom;
  endtask

  task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
    dif.wb_we = 1'b1; dif.wb_addr = a; dif.wb_data = d;
    tick();
    dif.wb_we = 1'b0;
  endtask

  task automatic check_bundle(input string tag);
    chk({tag, ".valid"},  32'(dif.out_valid), 32'd1);
    chk({tag, ".pc"},     dif.out_pc, cur_pc);
    chk({tag, ".rs1"},    dif.out_rs1_val, ref_op(cur_instr[19:15]));
    chk({tag, ".rs2"},    dif.out_rs2_val, ref_op(cur_instr[24:20]));
    chk({tag, ".imm"},    dif.out_imm, ref_imm(cur_instr));
    chk({tag, ".rd"},     32'(dif.out_rd), 32'(cur_instr[11:7]));
    chk({tag, ".opcode"}, 32'(dif.out_opcode), 32'(cur_instr[6:0]));
    chk({tag, ".funct3"}, 32'(dif.out_funct3), 32'(cur_instr[14:12]));
    chk({tag, ".f7b5"},   32'(dif.out_funct7b5), 32'(cur_instr[30]));
    chk({tag, ".illegal"},32'(dif.out_illegal), 32'(ref_illegal(cur_instr)));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".valid"},  32'(dif.out_valid), 32'd0);
    chk({tag, ".pc"},     dif.out_pc, 32'd0);
    chk({tag, ".rs1"},    dif.out_rs1_val, 32'd0);
    chk({tag, ".rs2"},    dif.out_rs2_val, 32'd0);
    chk({tag, ".imm"},    dif.out_imm, 32'd0);
    chk({tag, ".rd"},     32'(dif.out_rd), 32'd0);
    chk({tag, ".opcode"}, 32'(dif.out_opcode), 32'd0);
    chk({tag, ".funct3"}, 32'(dif.out_funct3), 32'd0);
    chk({tag, ".f7b5"},   32'(dif.out_funct7b5), 32'd0);
    chk({tag, ".illegal"},32'(dif.out_illegal), 32'd0);
  endtask

  task automatic accept_idle(input logic [31:0] ins, input logic [31:0] pc, input string tag);
    chk({tag, ".idle_inrdy"}, 32'(dif.in_ready), 32'd1);
    cur_instr = ins; cur_pc = pc;
    dif.in_valid = 1'b1; dif.in_instr = ins; dif.in_pc = pc;
    tick();
    dif.in_valid = 1'b0; dif.in_instr = $urandom; dif.in_pc = $urandom;
    chk({tag, ".read_ovalid"}, 32'(dif.out_valid), 32'd0);
    chk({tag, ".read_inrdy"},  32'(dif.in_ready), 32'd0);
  endtask

  // From READ: drive the writebacks for the READ and CAPT exit edges, then check the bundle.
  task automatic follow(input bit rnd, input bit we_r, input logic [4:0] a_r, input logic [31:0] d_r,
                        input bit we_c, input logic [4:0] a_c, input logic [31:0] d_c, input string tag);
    if (rnd) rand_wb();
    else begin dif.wb_we = we_r; dif.wb_addr = a_r; dif.wb_data = d_r; end
    tick();
    chk({tag, ".capt_ovalid"}, 32'(dif.out_valid), 32'd0);
    chk({tag, ".capt_inrdy"},  32'(dif.in_ready), 32'd0);
    if (rnd) rand_wb();
    else begin dif.wb_we = we_c; dif.wb_addr = a_c; dif.wb_data = d_c; end
    tick();
    dif.wb_we = 1'b0;
    check_bundle(tag);
  endtask

  task automatic deliver(input int stall, input bit nv, input logic [31:0] ni,
                         input logic [31:0] np, input string tag);
    for (int s = 0; s < stall; s++) begin
      dif.out_ready = 1'b0;
      dif.in_valid  = 1'(($urandom % 2));
      dif.in_instr  = $urandom;
      rand_wb();
      tick();
      dif.wb_we = 1'b0;
      chk({tag, ".stall_inrdy"}, 32'(dif.in_ready), 32'd0);
      check_bundle({tag, ".stall"});
    end
    dif.out_ready = 1'b1;
    rand_wb();
    dif.in_valid = nv; dif.in_instr = ni; dif.in_pc = np;
    #1;
    chk({tag, ".hs_inrdy"}, 32'(dif.in_ready), 32'd1);
    tick();
    dif.out_ready = 1'b0; dif.in_valid = 1'b0; dif.wb_we = 1'b0; dif.in_instr = $urandom;
    chk({tag, ".post_ovalid"}, 32'(dif.out_valid), 32'd0);
    if (nv) begin
      cur_instr = ni; cur_pc = np;
      chk({tag, ".b2b_inrdy"}, 32'(dif.in_ready), 32'd0);
    end else begin
      chk({tag, ".idle_inrdy"}, 32'(dif.in_ready), 32'd1);
    end
  endtask

  initial begin
    bit          b2b;
    bit          nv;
    logic [31:0] ni;

    dif.in_valid = 1'b0; dif.in_instr = 32'd0; dif.in_pc = 32'd0;
    dif.out_ready = 1'b0; dif.wb_we = 1'b0; dif.wb_addr = 5'd0; dif.wb_data = 32'd0;

    for (int i = 0; i < 32; i++) wr_reg(5'(i), (i == 0) ? 32'h55AA55AA : $urandom);
    check_zero("reset");
    rst = 1'b1;
    tick();
    chk("reset.inrdy", 32'(dif.in_ready), 32'd1);

    // addi x5,x1,12
    wr_reg(5'd1, 32'h10);
    accept_idle(32'h00C08293, 32'h100, "addi");
    follow(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, "addi");
    chk("addi.rs1c", dif.out_rs1_val, 32'h10);
    chk("addi.immc", dif.out_imm, 32'h0000000C);
    chk("addi.rdc",  32'(dif.out_rd), 32'd5);
    chk("addi.opc",  32'(dif.out_opcode), 32'h13);
    deliver(0, 1'b0, 32'd0, 32'd0, "addi");

    // sw x2,-4(x1) with forwards at READ exit and CAPT exit
    accept_idle(32'hFE20AE23, 32'h104, "sw");
    follow(1'b0, 1'b1, 5'd1, 32'hDEAD, 1'b1, 5'd2, 32'hBEEF, "sw");
    chk("sw.rs1c", dif.out_rs1_val, 32'hDEAD);
    chk("sw.rs2c", dif.out_rs2_val, 32'hBEEF);
    chk("sw.immc", dif.out_imm, 32'hFFFFFFFC);
    deliver(0, 1'b0, 32'd0, 32'd0, "sw");

    // beq x0,x0,-8 with writes aimed at x0
    accept_idle(32'hFE000CE3, 32'h108, "beq");
    follow(1'b0, 1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h55, "beq");
    chk("beq.rs1c", dif.out_rs1_val, 32'd0);
    chk("beq.rs2c", dif.out_rs2_val, 32'd0);
    chk("beq.immc", dif.out_imm, 32'hFFFFFFF8);
    deliver(0, 1'b0, 32'd0, 32'd0, "beq");

    // add x3,x1,x2 held in VALID for 4 cycles, x2 written in cycle 2
    accept_idle(32'h002081B3, 32'h10C, "stall");
    follow(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, "stall");
    dif.out_ready = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 2) begin dif.wb_we = 1'b1; dif.wb_addr = 5'd2; dif.wb_data = 32'h77; end
      tick();
      dif.wb_we = 1'b0;
      chk("stall.rs2c", dif.out_rs2_val, (c >= 2) ? 32'h77 : ref_op(5'd2));
      check_bundle("stall.hold");
    end
    deliver(0, 1'b1, 32'h00000000, 32'h110, "stall");

    // illegal all-zero word, then back-to-back accept on the handshake edge
    follow(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, "illegal");
    chk("illegal.flag", 32'(dif.out_illegal), 32'd1);
    chk("illegal.immc", dif.out_imm, 32'd0);
    deliver(0, 1'b1, 32'h00C08293, 32'h114, "illegal");
    follow(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, "b2b");
    deliver(0, 1'b0, 32'd0, 32'd0, "b2b");

    // randomized traffic with stalls, writebacks and back-to-back accepts
    b2b = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (!b2b) accept_idle(gen_instr(), $urandom, "rnd");
      follow(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, "rnd");
      nv = (n == 59) ? 1'b0 : 1'(($urandom % 2));
      ni = gen_instr();
      deliver(int'($urandom_range(0, 3)), nv, ni, $urandom, "rnd");
      b2b = nv;
    end

    // asynchronous reset while in CAPT
    accept_idle(32'h00C08293, 32'h200, "prerst");
    follow(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, "prerst");
    deliver(0, 1'b0, 32'd0, 32'd0, "prerst");
    accept_idle(32'hFE20AE23, 32'h300, "rstcapt");
    tick();
    rst = 1'b0;
    #1;
    check_zero("rstcapt");
    tick();
    rst = 1'b1;
    tick();
    chk("rstcapt.inrdy", 32'(dif.in_ready), 32'd1);
    chk("rstcapt.ovalid", 32'(dif.out_valid), 32'd0);
    accept_idle(32'h123452B7, 32'h400, "lui");
    follow(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, "lui");
    chk("lui.immc", dif.out_imm, 32'h12345000);
    chk("lui.rdc",  32'(dif.out_rd), 32'd5);
    deliver(1, 1'b0, 32'd0, 32'd0, "lui");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decode_stage.md
# decode_stage

Instruction decode / register-read stage of the RISC-V pipeline. It accepts a fetched instruction and PC over a valid/ready handshake, extracts the register fields and sign-extended immediate, and drives the read addresses of the register file. It absorbs the register file's one-cycle registered read latency, forwards same-cycle and later writebacks that the register file does not yet reflect, and presents a decoded bundle to the execute stage over a second valid/ready handshake.

## Interface
- No parameters. XLEN is fixed at 32 and there are 32 registers.
- Clock and reset: one clock. Reset is asynchronous and active-low.
- clk  in  1  rising-edge clock shared with the register file
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  stage can accept
- in_instr  in  32  instruction word
- in_pc  in  32  instruction address
- rf_a1, rf_a2  out  5  register-file read addresses (rs1, rs2)
- rf_rd1, rf_rd2  in  32  register-file read data, registered one edge after the address
- wb_we, wb_addr[4:0], wb_data[31:0]  in  —  writeback snoop; the same nets drive the register file's WE3/A3/WD3
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts
- out_pc  out  32  PC of the decoded instruction
- out_rs1_val, out_rs2_val  out  32  operand values
- out_imm  out  32  sign-extended immediate
- out_rd  out  5  destination register
- out_opcode  out  7  opcode
- out_funct3  out  3  funct3
- out_funct7b5  out  1  bit 30 of the instruction
- out_illegal  out  1  unsupported encoding

## Operation
- FSM states: IDLE, READ, CAPT, VALID. Reset enters IDLE.
- IDLE: in_ready=1. On in_valid, latch in_instr and in_pc, then go to READ.
- READ: rf_a1/rf_a2 = latched instr[19:15]/[24:20]. The register file samples its addresses at this state's exit edge. Go to CAPT.
- CAPT: rf_rd1/rf_rd2 are valid. At the exit edge, load the out_* registers and go to VALID.
- VALID: out_valid=1. Hold all out_* until out_valid && out_ready.
  - On handshake with in_valid=1: accept the new instruction on the same edge and go to READ.
  - On handshake with in_valid=0: go to IDLE.
- in_ready = (state==IDLE) || (state==VALID && out_ready). in_ready is 0 in READ and CAPT.
- Forwarding:
  - The register file returns the old value when a read and write hit the same edge.
  - At READ exit, if wb_we and wb_addr matches rs1 (or rs2), store wb_data in a pending slot per operand and set its flag.
  - At CAPT exit, operand priority is: live wb match at that edge, then pending slot, then rf_rdN.
  - In VALID, any wb_we matching rs1/rs2 updates out_rs1_val/out_rs2_val at that edge.
- x0 handling: an operand whose address is 0 is always 0x00000000. x0 never matches a forward.
- Immediate by opcode:
  - I-type (0010011, 0000011, 1100111): instr[31:20] sign-extended.
  - S-type (0100011): {instr[31:25], instr[11:7]} sign-extended.
  - B-type (1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 0} sign-extended.
  - U-type (0110111, 0010111): {instr[31:12], 12'b0}.
  - J-type (1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 0} sign-extended.
  - R-type (0110011): 0.
- out_illegal=1 when instr[1:0]!=2'b11 or the opcode is not in the list above. For an illegal instruction out_imm=0; the bundle is still delivered.

## Timing
- Reset (asynchronous assert, any state): state=IDLE, all out_* = 0, out_valid=0, pending flags cleared, latched instr/pc = 0. An instruction in flight is dropped.
- in_ready after reset is 1 once rst is released.
- Latency: accept at edge E0 gives out_valid=1 after edge E2 (3 edges).
- Peak throughput: one instruction per 3 cycles.
- A simultaneous handshake and accept in VALID is legal. No bubble beyond READ and CAPT.
- out_* change only at the CAPT exit edge, or in VALID via forwarding. They are stable otherwise.
- rf_a1/rf_a2 hold the latched fields in every state. The register file tolerates this.

## Test plan
- addi x5,x1,12 (0x00C08293), x1=0x10 -> out_valid 3 edges after accept; rs1_val=0x10, imm=0x0000000C, rd=5, opcode=0x13, illegal=0.
- sw x2,-4(x1) (0xFE20AE23) with write x1=0xDEAD at READ exit, and write x2=0xBEEF at CAPT exit -> rs1_val=0xDEAD, rs2_val=0xBEEF, imm=0xFFFFFFFC.
- beq x0,x0,-8 (0xFE000CE3) with wb x0=0x55 -> both operand values 0, imm=0xFFFFFFF8.
- Stall: out_ready=0 for 4 cycles in VALID with rs2=x2, write x2=0x77 in cycle 2 -> out_rs2_val becomes 0x77 on the next edge; other fields unchanged.
- 0x00000000 -> illegal=1, imm=0. Then back-to-back handshake with the next instruction accepted on the same edge -> next out_valid 3 edges later.
- Assert rst in CAPT -> out_valid=0 and all out_* = 0 immediately. After release, in_ready=1 and a fresh instruction decodes normally.
